// File: rtl/video_timing_detector.sv
// video_timing_detector
// Watches a raw hs/vs/de stream in the pixel clock domain. It recovers the pixel
// coordinates, measures line/frame totals, active sizes and sync polarities, and
// reports lock once two consecutive valid frames measure identically.
//
// Ports:
//   clk_rgb, rst (sync, active-high), ce (clock enable; low holds all state)
//   hs, vs, de            raw timing inputs of unknown sync polarity
//   x, y, de_out          pixel coordinates aligned with de delayed by one cycle
//   frame_start           one-cycle pulse following each vs active edge
//   hor_total/hor_active  measured line period and active width
//   ver_total/ver_active  measured lines per frame and active lines
//   hs_polarity/vs_polarity  1 = active-high sync
//   locked                measurements stable
module video_timing_detector #(
    parameter int unsigned HOR_COUNTER_WIDTH = 11,
    parameter int unsigned VER_COUNTER_WIDTH = 11
) (
    input  logic                         clk_rgb,
    input  logic                         rst,
    input  logic                         ce,
    input  logic                         hs,
    input  logic                         vs,
    input  logic                         de,
    output logic [HOR_COUNTER_WIDTH-1:0] x,
    output logic [VER_COUNTER_WIDTH-1:0] y,
    output logic                         de_out,
    output logic                         frame_start,
    output logic [HOR_COUNTER_WIDTH-1:0] hor_total,
    output logic [HOR_COUNTER_WIDTH-1:0] hor_active,
    output logic [VER_COUNTER_WIDTH-1:0] ver_total,
    output logic [VER_COUNTER_WIDTH-1:0] ver_active,
    output logic                         hs_polarity,
    output logic                         vs_polarity,
    output logic                         locked
);

    localparam int unsigned HW = HOR_COUNTER_WIDTH;
    localparam int unsigned VW = VER_COUNTER_WIDTH;
    localparam logic [HW-1:0] H_MAX  = {HW{1'b1}};
    localparam logic [VW-1:0] V_MAX  = {VW{1'b1}};
    localparam logic [HW-1:0] H_ONE  = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [VW-1:0] V_ONE  = {{(VW-1){1'b0}}, 1'b1};

    // Input history and polarity
    logic hs_q, vs_q, de_q;
    logic hs_pol_q, hs_pol_d, vs_pol_q, vs_pol_d;
    // Running counters
    logic [HW-1:0] h_cnt_q, h_cnt_d, run_len_q, run_len_d;
    // Per-frame state
    logic [HW-1:0] h_first_q, h_first_d, run_first_q, run_first_d;
    logic          h_have_q, h_have_d, run_have_q, run_have_d, bad_q, bad_d;
    logic [VW-1:0] line_cnt_q, line_cnt_d, run_cnt_q, run_cnt_d;
    // Outputs
    logic [HW-1:0] x_q, x_d, hor_total_q, hor_total_d, hor_active_q, hor_active_d;
    logic [VW-1:0] y_q, y_d, ver_total_q, ver_total_d, ver_active_q, ver_active_d;
    logic          frame_start_q, locked_q, locked_d;
    logic [1:0]    match_q, match_d;

    logic          hs_edge, vs_edge, de_rise, de_fall, h_sat, frame_valid, same;
    logic [HW-1:0] period;

    assign hs_edge = (hs_q != hs_pol_q) && (hs == hs_pol_q);
    assign vs_edge = (vs_q != vs_pol_q) && (vs == vs_pol_q);
    assign de_rise = de && !de_q;
    assign de_fall = !de && de_q;
    assign period  = h_cnt_q + H_ONE;

    always_comb begin
        hs_pol_d     = hs_pol_q;
        vs_pol_d     = vs_pol_q;
        h_first_d    = h_first_q;
        h_have_d     = h_have_q;
        run_first_d  = run_first_q;
        run_have_d   = run_have_q;
        run_cnt_d    = run_cnt_q;
        line_cnt_d   = line_cnt_q;
        bad_d        = bad_q;
        hor_total_d  = hor_total_q;
        hor_active_d = hor_active_q;
        ver_total_d  = ver_total_q;
        ver_active_d = ver_active_q;
        match_d      = match_q;
        frame_valid  = 1'b0;
        same         = 1'b0;

        // Sync is never active during active video, so de rising reveals polarity.
        if (de_rise) begin
            hs_pol_d = ~hs;
            vs_pol_d = ~vs;
        end

        h_cnt_d = hs_edge ? '0 : ((h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + H_ONE);
        h_sat   = (h_cnt_d == H_MAX);
        if (h_sat) bad_d = 1'b1;

        run_len_d = de ? (de_rise ? H_ONE : ((run_len_q == H_MAX) ? H_MAX : run_len_q + H_ONE))
                       : run_len_q;
        if (de && run_len_d == H_MAX) bad_d = 1'b1;

        if (hs_edge) begin
            if (!h_have_q) begin
                h_first_d = period;
                h_have_d  = 1'b1;
            end else if (period != h_first_q) begin
                bad_d = 1'b1;
            end
            if (line_cnt_q == V_MAX) bad_d = 1'b1;
            else line_cnt_d = line_cnt_q + V_ONE;
        end

        if (de_fall) begin
            if (!run_have_q) begin
                run_first_d = run_len_q;
                run_have_d  = 1'b1;
            end else if (run_len_q != run_first_q) begin
                bad_d = 1'b1;
            end
            if (run_cnt_q == V_MAX) bad_d = 1'b1;
            else run_cnt_d = run_cnt_q + V_ONE;
        end

        if (vs_edge) begin
            // A coincident hs edge belongs to the new frame, so line_cnt_q (without it)
            // is the line total of the frame just ended.
            hor_total_d  = h_first_d;
            hor_active_d = run_first_d;
            ver_total_d  = line_cnt_q;
            ver_active_d = run_cnt_d;
            frame_valid  = !bad_d && (h_first_d != '0) && (run_first_d != '0) &&
                           (line_cnt_q != '0) && (run_cnt_d != '0);
            same         = (hor_total_d == hor_total_q) && (hor_active_d == hor_active_q) &&
                           (ver_total_d == ver_total_q) && (ver_active_d == ver_active_q);
            if (!frame_valid)        match_d = 2'd0;
            else if (!same)          match_d = 2'd1;
            else if (match_q != 2'd2) match_d = match_q + 2'd1;

            h_have_d    = hs_edge;
            h_first_d   = hs_edge ? period : '0;
            line_cnt_d  = hs_edge ? V_ONE : '0;
            run_first_d = '0;
            run_have_d  = 1'b0;
            run_cnt_d   = '0;
            bad_d       = 1'b0;
        end

        // Lost hs: drop lock immediately, keep the last published measurements.
        if (h_sat) match_d = 2'd0;
        locked_d = (match_d == 2'd2);

        x_d = (de && de_q) ? ((x_q == H_MAX) ? H_MAX : x_q + H_ONE) : '0;
        if (vs_edge)      y_d = '0;
        else if (de_fall) y_d = (y_q == V_MAX) ? V_MAX : y_q + V_ONE;
        else              y_d = y_q;
    end

    always_ff @(posedge clk_rgb) begin
        if (rst) begin
            hs_q <= 1'b0;  vs_q <= 1'b0;  de_q <= 1'b0;
            hs_pol_q <= 1'b0;  vs_pol_q <= 1'b0;
            h_cnt_q <= '0;  run_len_q <= '0;
            h_first_q <= '0;  h_have_q <= 1'b0;
            run_first_q <= '0;  run_have_q <= 1'b0;  run_cnt_q <= '0;
            line_cnt_q <= '0;  bad_q <= 1'b0;
            x_q <= '0;  y_q <= '0;  frame_start_q <= 1'b0;
            hor_total_q <= '0;  hor_active_q <= '0;
            ver_total_q <= '0;  ver_active_q <= '0;
            match_q <= 2'd0;  locked_q <= 1'b0;
        end else if (ce) begin
            hs_q <= hs;  vs_q <= vs;  de_q <= de;
            hs_pol_q <= hs_pol_d;  vs_pol_q <= vs_pol_d;
            h_cnt_q <= h_cnt_d;  run_len_q <= run_len_d;
            h_first_q <= h_first_d;  h_have_q <= h_have_d;
            run_first_q <= run_first_d;  run_have_q <= run_have_d;  run_cnt_q <= run_cnt_d;
            line_cnt_q <= line_cnt_d;  bad_q <= bad_d;
            x_q <= x_d;  y_q <= y_d;  frame_start_q <= vs_edge;
            hor_total_q <= hor_total_d;  hor_active_q <= hor_active_d;
            ver_total_q <= ver_total_d;  ver_active_q <= ver_active_d;
            match_q <= match_d;  locked_q <= locked_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de_out      = de_q;
    assign frame_start = frame_start_q;
    assign hor_total   = hor_total_q;
    assign hor_active  = hor_active_q;
    assign ver_total   = ver_total_q;
    assign ver_active  = ver_active_q;
    assign hs_polarity = hs_pol_q;
    assign vs_polarity = vs_pol_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_video_timing_detector.sv
// Scoreboard bench for video_timing_detector: the stimulus generator pushes expected
// pixels and frame records; a monitor pops and compares them as the DUT presents them.
module tb_video_timing_detector;

    logic        clk_rgb = 1'b0;
    logic        rst = 1'b1, ce = 1'b1, hs = 1'b1, vs = 1'b1, de = 1'b0;
    logic [10:0] x, hor_total, hor_active;
    logic [10:0] y, ver_total, ver_active;
    logic        de_out, frame_start, hs_polarity, vs_polarity, locked;

    video_timing_detector dut (
        .clk_rgb(clk_rgb), .rst(rst), .ce(ce), .hs(hs), .vs(vs), .de(de),
        .x(x), .y(y), .de_out(de_out), .frame_start(frame_start),
        .hor_total(hor_total), .hor_active(hor_active),
        .ver_total(ver_total), .ver_active(ver_active),
        .hs_polarity(hs_polarity), .vs_polarity(vs_polarity), .locked(locked)
    );

    always #5 clk_rgb = ~clk_rgb;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct { int px; int py; } pix_t;
    typedef struct { bit meas; bit lock; int ht; int ha; int vt; int va; int pol; } frm_t;
    pix_t pix_q[$];
    frm_t frm_q[$];

    // Current timing under test
    int h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp;
    bit pos, coin;

    task automatic set_timing(input int ha, input int hf, input int hsy, input int hb,
                              input int va, input int vf, input int vsy, input int vb,
                              input bit p, input bit c);
        h_act = ha; h_fp = hf; h_sync = hsy; h_bp = hb;
        v_act = va; v_fp = vf; v_sync = vsy; v_bp = vb;
        pos = p; coin = c;
    endtask

    // Drive one cycle; hs_a/vs_a are sync-active levels, mapped through polarity.
    task automatic drive(input bit hs_a, input bit vs_a, input bit d);
        hs = pos ? hs_a : !hs_a;
        vs = pos ? vs_a : !vs_a;
        de = d;
        @(posedge clk_rgb);
        @(negedge clk_rgb);
    endtask

    // Monitor: outputs only advance on enabled, non-reset edges.
    bit adv = 1'b0;
    always @(posedge clk_rgb) adv = ce && !rst;

    always @(negedge clk_rgb) begin
        if (adv) begin
            if (de_out) begin
                if (pix_q.size() == 0) begin
                    check("pixel_unexpected", 1, 0);
                end else begin
                    pix_t e;
                    e = pix_q.pop_front();
                    check("x", int'(x), e.px);
                    check("y", int'(y), e.py);
                end
            end
            if (frame_start) begin
                if (frm_q.size() == 0) begin
                    check("frame_unexpected", 1, 0);
                end else begin
                    frm_t f;
                    f = frm_q.pop_front();
                    check("locked", int'(locked), int'(f.lock));
                    if (f.meas) begin
                        check("hor_total", int'(hor_total), f.ht);
                        check("hor_active", int'(hor_active), f.ha);
                        check("ver_total", int'(ver_total), f.vt);
                        check("ver_active", int'(ver_active), f.va);
                        check("hs_polarity", int'(hs_polarity), f.pol);
                        check("vs_polarity", int'(vs_polarity), f.pol);
                    end
                end
            end
        end
    end

    // One full frame starting at the top-left active pixel.
    task automatic run_frame(input bit meas, input bit lock, input int short_line,
                             input int gap_line);
        int ht, vt, hs_s, vs_start, vs_end;
        ht = h_act + h_fp + h_sync + h_bp;
        vt = v_act + v_fp + v_sync + v_bp;
        hs_s = h_act + h_fp;
        vs_start = (v_act + v_fp) * ht + (coin ? hs_s : 0);
        vs_end = vs_start + v_sync * ht;
        for (int line = 0; line < vt; line++) begin
            for (int col = 0; col < ht; col++) begin
                int p;
                bit d, ha, va;
                p  = line * ht + col;
                d  = (line < v_act) && (col < ((line == short_line) ? h_act - 2 : h_act));
                ha = (col >= hs_s) && (col < hs_s + h_sync);
                va = (p >= vs_start) && (p < vs_end);
                if (line == gap_line && col == h_act / 2) begin
                    ce = 1'b0;
                    repeat (100) drive(1'b0, 1'b0, 1'b1);
                    check("gap_x", int'(x), col - 1);
                    check("gap_y", int'(y), line);
                    check("gap_de_out", int'(de_out), 1);
                    ce = 1'b1;
                end
                if (p == vs_start) begin
                    frm_t f;
                    f = '{meas, lock, ht, h_act, vt, v_act, int'(pos)};
                    frm_q.push_back(f);
                end
                if (d) begin
                    pix_t e;
                    e = '{col, line};
                    pix_q.push_back(e);
                end
                drive(ha, va, d);
            end
        end
    endtask

    task automatic reset_check();
        rst = 1'b1;
        repeat (4) begin
            hs = 1'($urandom); vs = 1'($urandom); de = 1'($urandom);
            @(posedge clk_rgb);
            @(negedge clk_rgb);
        end
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_de_out", int'(de_out), 0);
        check("rst_frame_start", int'(frame_start), 0);
        check("rst_hor_total", int'(hor_total), 0);
        check("rst_hor_active", int'(hor_active), 0);
        check("rst_ver_total", int'(ver_total), 0);
        check("rst_ver_active", int'(ver_active), 0);
        check("rst_hs_polarity", int'(hs_polarity), 0);
        check("rst_vs_polarity", int'(vs_polarity), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_pending_pixels", pix_q.size(), 0);
        check("rst_pending_frames", frm_q.size(), 0);
        pix_q.delete();
        frm_q.delete();
        rst = 1'b0;
    endtask

    // Start a frame, stop after line 0's hs edge, then starve hs.
    task automatic timeout_test();
        int hs_s;
        hs_s = h_act + h_fp;
        for (int col = 0; col <= hs_s; col++) begin
            if (col < h_act) begin
                pix_t e;
                e = '{col, 0};
                pix_q.push_back(e);
            end
            drive(col == hs_s, 1'b0, col < h_act);
        end
        for (int n = 1; n <= 2060; n++) begin
            drive(1'b0, 1'b0, 1'b0);
            if (n == 2046) check("timeout_locked_before", int'(locked), 1);
            if (n == 2047) check("timeout_locked_at_2047", int'(locked), 0);
        end
        check("timeout_locked_after", int'(locked), 0);
        check("timeout_hor_total", int'(hor_total), 56);
        check("timeout_hor_active", int'(hor_active), 40);
        check("timeout_ver_total", int'(ver_total), 31);
        check("timeout_ver_active", int'(ver_active), 24);
    endtask

    initial begin
        // Negative sync, 56/40 x 31/24
        set_timing(40, 4, 6, 6, 24, 2, 2, 3, 1'b0, 1'b0);
        reset_check();
        run_frame(1'b0, 1'b0, -1, -1);
        run_frame(1'b1, 1'b0, -1, -1);
        run_frame(1'b1, 1'b1, -1, -1);
        run_frame(1'b1, 1'b1, -1, 5);   // ce gap mid-line
        run_frame(1'b1, 1'b0, 2, -1);   // one short de run
        run_frame(1'b1, 1'b0, -1, -1);
        run_frame(1'b1, 1'b1, -1, -1);
        timeout_test();

        // Positive sync, 20/12 x 10/6
        set_timing(12, 2, 3, 3, 6, 1, 1, 2, 1'b1, 1'b0);
        reset_check();
        run_frame(1'b0, 1'b0, -1, -1);
        run_frame(1'b1, 1'b0, -1, -1);
        run_frame(1'b1, 1'b1, -1, -1);

        // Negative sync with vs edges coincident with hs edges
        set_timing(40, 4, 6, 6, 24, 2, 2, 3, 1'b0, 1'b1);
        reset_check();
        run_frame(1'b0, 1'b0, -1, -1);
        run_frame(1'b1, 1'b0, -1, -1);
        run_frame(1'b1, 1'b1, -1, -1);

        repeat (4) drive(1'b0, 1'b0, 1'b0);
        check("end_pending_pixels", pix_q.size(), 0);
        check("end_pending_frames", frm_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
